// File: rtl/csi2tx_lane_byte_tracker.sv
// Packet-progress tracker between the CSI byte FIFO read port and the lane distributor.
// Decodes the packet header, then counts FIFO bytes read and lane bytes committed.
module csi2tx_lane_byte_tracker #(
    parameter int unsigned MAX_LANES = 8
) (
    input  logic        txbyteclkhs,
    input  logic        txbyteclkhs_rst,
    input  logic        forcetxstopmode,
    input  logic [3:0]  lane_cnt,
    input  logic        header_info,
    input  logic        fifo_rd_en,
    input  logic [63:0] fifo_rd_data,
    input  logic        txreadyhs0,
    input  logic        txrequesths0,
    output logic [63:0] fifo_rd_data_d,
    output logic        short_packet,
    output logic [16:0] validated_word_cnt,
    output logic        eop_rd,
    output logic        eop_wr,
    output logic        pkt_err
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    localparam logic [3:0] MAX_L = 4'(MAX_LANES);

    state_t      state_q, state_d;
    logic [16:0] vwc_q, vwc_d;
    logic [16:0] rd_bytes_q, rd_bytes_d;
    logic [16:0] total_q, total_d;
    logic [3:0]  lanes_q, lanes_d;
    logic        short_q, short_d;
    logic        err_q, err_d;
    logic [63:0] data_d_q, data_d_d;

    logic        beat;
    logic        last_beat;
    logic [3:0]  lanes_eff;
    logic [16:0] lanes_ext;
    logic        hdr_short;
    logic [16:0] hdr_total;

    assign beat      = txreadyhs0 & txrequesths0;
    assign lanes_ext = {13'b0, lanes_q};
    assign hdr_short = (fifo_rd_data[5:0] < 6'h10);
    assign hdr_total = hdr_short ? 17'd4 : ({1'b0, fifo_rd_data[23:8]} + 17'd6);

    always_comb begin
        lanes_eff = lane_cnt;
        if (lane_cnt == 4'd0) begin
            lanes_eff = 4'd1;
        end else if (lane_cnt > MAX_L) begin
            lanes_eff = MAX_L;
        end
    end

    // A short packet fits in one beat regardless of the lane count.
    assign last_beat = (state_q == ACTIVE) && beat && (short_q || (vwc_q <= lanes_ext));

    always_comb begin
        state_d    = state_q;
        vwc_d      = vwc_q;
        rd_bytes_d = rd_bytes_q;
        total_d    = total_q;
        lanes_d    = lanes_q;
        short_d    = short_q;
        data_d_d   = data_d_q;
        err_d      = (header_info && (state_q != IDLE)) || (beat && (state_q == IDLE));

        case (state_q)
            IDLE: begin
                if (header_info) begin
                    vwc_d      = hdr_total;
                    total_d    = hdr_total;
                    rd_bytes_d = 17'd8;
                    lanes_d    = lanes_eff;
                    short_d    = hdr_short;
                    state_d    = ACTIVE;
                end
            end
            ACTIVE: begin
                if (fifo_rd_en) begin
                    rd_bytes_d = (rd_bytes_q >= 17'h1FFF8) ? '1 : (rd_bytes_q + 17'd8);
                end
                if (beat) begin
                    vwc_d = (vwc_q > lanes_ext) ? (vwc_q - lanes_ext) : '0;
                end
                if (last_beat) begin
                    state_d    = DONE;
                    vwc_d      = '0;
                    rd_bytes_d = '0;
                    short_d    = 1'b0;
                end
            end
            DONE: begin
                state_d    = IDLE;
                vwc_d      = '0;
                rd_bytes_d = '0;
                short_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        if (fifo_rd_en) begin
            data_d_d = fifo_rd_data;
        end

        if (forcetxstopmode) begin
            state_d    = IDLE;
            vwc_d      = '0;
            rd_bytes_d = '0;
            total_d    = '0;
            lanes_d    = '0;
            short_d    = 1'b0;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge txbyteclkhs or posedge txbyteclkhs_rst) begin
        if (txbyteclkhs_rst) begin
            state_q    <= IDLE;
            vwc_q      <= '0;
            rd_bytes_q <= '0;
            total_q    <= '0;
            lanes_q    <= '0;
            short_q    <= 1'b0;
            err_q      <= 1'b0;
            data_d_q   <= '0;
        end else begin
            state_q    <= state_d;
            vwc_q      <= vwc_d;
            rd_bytes_q <= rd_bytes_d;
            total_q    <= total_d;
            lanes_q    <= lanes_d;
            short_q    <= short_d;
            err_q      <= err_d;
            data_d_q   <= data_d_d;
        end
    end

    assign fifo_rd_data_d     = data_d_q;
    assign short_packet       = short_q;
    assign validated_word_cnt = vwc_q;
    assign eop_rd             = (state_q == ACTIVE) && (rd_bytes_q >= total_q);
    assign eop_wr             = last_beat && !forcetxstopmode;
    assign pkt_err            = err_q;

endmodule

// File: tb/tb_csi2tx_lane_byte_tracker.sv
// Scoreboard bench for csi2tx_lane_byte_tracker: a behavioural model pushes expected
// outputs per driven cycle; they are popped and compared once the DUT responds.
module tb_csi2tx_lane_byte_tracker;

    logic        txbyteclkhs = 1'b0;
    logic        txbyteclkhs_rst = 1'b1;
    logic        forcetxstopmode = 1'b0;
    logic [3:0]  lane_cnt = '0;
    logic        header_info = 1'b0;
    logic        fifo_rd_en = 1'b0;
    logic [63:0] fifo_rd_data = '0;
    logic        txreadyhs0 = 1'b0;
    logic        txrequesths0 = 1'b0;
    logic [63:0] fifo_rd_data_d;
    logic        short_packet;
    logic [16:0] validated_word_cnt;
    logic        eop_rd;
    logic        eop_wr;
    logic        pkt_err;

    csi2tx_lane_byte_tracker #(.MAX_LANES(8)) dut (
        .txbyteclkhs        (txbyteclkhs),
        .txbyteclkhs_rst    (txbyteclkhs_rst),
        .forcetxstopmode    (forcetxstopmode),
        .lane_cnt           (lane_cnt),
        .header_info        (header_info),
        .fifo_rd_en         (fifo_rd_en),
        .fifo_rd_data       (fifo_rd_data),
        .txreadyhs0         (txreadyhs0),
        .txrequesths0       (txrequesths0),
        .fifo_rd_data_d     (fifo_rd_data_d),
        .short_packet       (short_packet),
        .validated_word_cnt (validated_word_cnt),
        .eop_rd             (eop_rd),
        .eop_wr             (eop_wr),
        .pkt_err            (pkt_err)
    );

    always #5 txbyteclkhs = ~txbyteclkhs;

    typedef struct packed {
        logic [16:0] vwc;
        logic        sp;
        logic        erd;
        logic        err;
        logic [63:0] dd;
    } reg_exp_t;

    reg_exp_t reg_q[$];
    logic     wr_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: 0 = idle, 1 = active, 2 = done
    int          m_state;
    logic [16:0] m_vwc, m_rd, m_total, m_lanes;
    logic        m_short, m_err;
    logic [63:0] m_dd;
    logic        last_wr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_state = 0; m_vwc = '0; m_rd = '0; m_total = '0; m_lanes = '0;
        m_short = 1'b0; m_err = 1'b0; m_dd = '0; last_wr = 1'b0;
    endtask

    function automatic logic [63:0] hdr(input logic [7:0] di, input logic [15:0] wc);
        logic [31:0] up;
        up = $urandom;
        return {up, 8'h5A, wc, di};
    endfunction

    function automatic logic [63:0] rnd64();
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        return {a, b};
    endfunction

    task automatic cyc(input logic hi, input logic rd, input logic bt, input logic frc,
                       input logic [63:0] data);
        logic     w;
        reg_exp_t e;
        int       r, le, t;
        @(negedge txbyteclkhs);
        header_info     = hi;
        fifo_rd_en      = rd;
        fifo_rd_data    = data;
        forcetxstopmode = frc;
        if (bt) begin
            txreadyhs0 = 1'b1; txrequesths0 = 1'b1;
        end else begin
            r = int'($urandom_range(0, 2));
            txreadyhs0 = (r == 1); txrequesths0 = (r == 2);
        end
        #1;
        w = !frc && bt && (m_state == 1) && (m_short || (m_vwc <= m_lanes));
        wr_q.push_back(w);
        last_wr = eop_wr;
        check("eop_wr", eop_wr, wr_q.pop_front());

        if (rd) m_dd = data;
        if (frc) begin
            m_state = 0; m_vwc = '0; m_rd = '0; m_short = 1'b0; m_err = 1'b0;
        end else begin
            m_err = (hi && m_state != 0) || (bt && m_state == 0);
            if (m_state == 0) begin
                if (hi) begin
                    le = int'(lane_cnt);
                    if (le == 0) le = 1;
                    if (le > 8) le = 8;
                    m_lanes = 17'(le);
                    m_short = (data[5:0] < 6'h10);
                    m_total = m_short ? 17'd4 : 17'(int'(data[23:8]) + 6);
                    m_vwc   = m_total;
                    m_rd    = 17'd8;
                    m_state = 1;
                end
            end else if (m_state == 1) begin
                if (w) begin
                    m_state = 2; m_vwc = '0; m_rd = '0; m_short = 1'b0;
                end else begin
                    if (bt) m_vwc = (m_vwc > m_lanes) ? m_vwc - m_lanes : '0;
                    if (rd) begin
                        t = int'(m_rd) + 8;
                        m_rd = (t > 'h1FFFF) ? 17'h1FFFF : 17'(t);
                    end
                end
            end else begin
                m_state = 0; m_vwc = '0; m_rd = '0; m_short = 1'b0;
            end
        end
        e.vwc = m_vwc;
        e.sp  = m_short;
        e.erd = (m_state == 1) && (m_rd >= m_total);
        e.err = m_err;
        e.dd  = m_dd;
        reg_q.push_back(e);

        @(posedge txbyteclkhs);
        #1;
        e = reg_q.pop_front();
        check("validated_word_cnt", validated_word_cnt, e.vwc);
        check("short_packet", short_packet, e.sp);
        check("eop_rd", eop_rd, e.erd);
        check("pkt_err", pkt_err, e.err);
        check("fifo_rd_data_d", fifo_rd_data_d, e.dd);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, rnd64());
    endtask

    task automatic beats_until_eop(input int exp_n, input string tag);
        int n;
        n = 0;
        last_wr = 1'b0;
        while (!last_wr && n < 64) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd64());
            n++;
        end
        check(tag, n, exp_n);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vwc"}, validated_word_cnt, 0);
        check({tag, "_short"}, short_packet, 0);
        check({tag, "_eop_rd"}, eop_rd, 0);
        check({tag, "_eop_wr"}, eop_wr, 0);
        check({tag, "_pkt_err"}, pkt_err, 0);
        check({tag, "_data_d"}, fifo_rd_data_d, 0);
    endtask

    initial begin
        logic [63:0] keep;
        int          le, nb, exp_b, wc;
        logic [7:0]  di;
        logic        sp;

        model_reset();
        #12;
        check_all_zero("reset");
        txbyteclkhs_rst = 1'b0;

        // Long packet, 6 lanes, continuous beats: 16 -> 10 -> 4
        lane_cnt = 4'd6;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, hdr(8'h2A, 16'd10));
        check("hdr_vwc_16", validated_word_cnt, 17'd16);
        check("hdr_long", short_packet, 0);
        beats_until_eop(3, "long6_beats");
        idle();

        // Same packet with one read after header
        cyc(1'b1, 1'b0, 1'b0, 1'b0, hdr(8'h2A, 16'd10));
        cyc(1'b0, 1'b1, 1'b0, 1'b0, rnd64());
        check("eop_rd_after_read", eop_rd, 1);
        beats_until_eop(3, "long6_rd_beats");
        idle();

        // Same packet with no read
        cyc(1'b1, 1'b0, 1'b0, 1'b0, hdr(8'h2A, 16'd10));
        idle();
        check("eop_rd_no_read", eop_rd, 0);
        beats_until_eop(3, "long6_nord_beats");
        idle();

        // Short packet
        lane_cnt = 4'd4;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, hdr(8'h00, 16'h1234));
        check("short_set", short_packet, 1);
        check("short_vwc", validated_word_cnt, 17'd4);
        beats_until_eop(1, "short_beats");
        check("short_clear_done", short_packet, 0);
        idle();

        // Lane count saturation
        lane_cnt = 4'd0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, hdr(8'h2A, 16'd2));
        beats_until_eop(8, "lane0_beats");
        idle();
        lane_cnt = 4'd12;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, hdr(8'h2A, 16'd100));
        beats_until_eop(14, "lane12_beats");
        idle();

        // Header during ACTIVE
        lane_cnt = 4'd6;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, hdr(8'h2A, 16'd10));
        cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd64());
        cyc(1'b1, 1'b0, 1'b0, 1'b0, hdr(8'h2B, 16'd50));
        check("hdr_active_err", pkt_err, 1);
        check("hdr_active_vwc", validated_word_cnt, 17'd10);
        idle();
        check("err_one_cycle", pkt_err, 0);
        beats_until_eop(2, "after_err_beats");
        idle();

        // Beat in IDLE
        cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd64());
        check("beat_idle_err", pkt_err, 1);
        idle();

        // Forced stop mid-packet at cnt=40
        lane_cnt = 4'd4;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, hdr(8'h2A, 16'd34));
        check("force_pre_vwc", validated_word_cnt, 17'd40);
        keep = rnd64();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, keep);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, rnd64());
        check("force_vwc", validated_word_cnt, 0);
        check("force_eop_rd", eop_rd, 0);
        check("force_data_d", fifo_rd_data_d, keep);
        idle();

        // Asynchronous reset mid-packet
        lane_cnt = 4'd2;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, hdr(8'h2A, 16'd20));
        cyc(1'b0, 1'b1, 1'b1, 1'b0, rnd64());
        cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd64());
        #1;
        header_info = 1'b0; fifo_rd_en = 1'b0; forcetxstopmode = 1'b0;
        txreadyhs0 = 1'b0; txrequesths0 = 1'b0;
        txbyteclkhs_rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        #1;
        txbyteclkhs_rst = 1'b0;
        lane_cnt = 4'd3;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, hdr(8'h2A, 16'd7));
        check("post_rst_vwc", validated_word_cnt, 17'd13);
        beats_until_eop(5, "post_rst_beats");
        idle();

        // Random packets with sparse beats and reads
        for (int p = 0; p < 6; p++) begin
            lane_cnt = 4'($urandom_range(0, 15));
            wc = int'($urandom_range(0, 60));
            di = 8'($urandom);
            le = (lane_cnt == 0) ? 1 : ((lane_cnt > 8) ? 8 : int'(lane_cnt));
            sp = (di[5:0] < 6'h10);
            exp_b = sp ? 1 : (wc + 6 + le - 1) / le;
            cyc(1'b1, 1'b0, 1'b0, 1'b0, hdr(di, 16'(wc)));
            nb = 0;
            last_wr = 1'b0;
            for (int c = 0; c < 300 && !last_wr; c++) begin
                if ($urandom_range(0, 2) != 0) begin
                    cyc(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, rnd64());
                    nb++;
                end else begin
                    cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, rnd64());
                end
            end
            check("rand_beats", nb, exp_b);
            idle();
            idle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
